fft_agu_stream: RTL

- Runtime-configurable radix-2 FFT address generator for in-place, ping-pong-banked butterfly datapaths.
- Successor of the fixed-size AGU, adding:
  - FFT size selected at start (log2n up to MAX_LOG2N);
  - valid/ready stall on the read side;
  - parametrised write-back latency with a tracked pipeline;
  - in-flight-count-based stage drain instead of a fixed wait;
  - explicit read/write bank outputs.
- Sits between the control FSM and the two sample RAM banks plus the twiddle ROM.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_agu_delay.sv | 37 +++
 rtl/fft_agu_stream.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the streaming radix-2 FFT address generator.
// Provides default sizes, the control FSM state type, and the bit-rotate
// and twiddle-mask helpers used to derive butterfly and twiddle addresses.
package fft_pkg;

    localparam int MAX_LOG2N_DEF = 10;
    localparam int TW_WIDTH_DEF  = MAX_LOG2N_DEF - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } agu_state_t;

    // Rotate x left by k positions within its low l bits; bits above l are 0.
    // Requires k < l. Bits pushed past position l-1 wrap back to the bottom.
    function automatic logic [31:0] rotl_l(input logic [31:0] x, input int k, input int l);
        logic [63:0] mask;
        logic [63:0] t;
        logic [63:0] r;
        mask = (64'd1 << l) - 64'd1;
        t    = ({32'd0, x} & mask) << k;
        r    = (t & mask) | (t >> l);
        return r[31:0];
    endfunction

    // Twiddle index: j with its low (l-1-s) bits cleared.
    function automatic logic [31:0] tw_mask(input logic [31:0] j, input int s, input int l);
        int sh;
        sh = l - 1 - s;
        if (sh < 0) sh = 0;
        return j & ~((32'd1 << sh) - 32'd1);
    endfunction

endpackage

// File: rtl/fft_agu_delay.sv
// Fixed-depth shift register tracking write-backs {valid, payload}.
// Latency: DEPTH cycles from input to output; synchronous flush on clr.
// No backpressure: one entry accepted and one retired every cycle.
// Ports: clk, clr (sync flush), valid/data in, dly_valid/dly_data out.
module fft_agu_delay #(
    parameter int W     = 21,
    parameter int DEPTH = 5
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         valid,
    input  logic [W-1:0] data,
    output logic         dly_valid,
    output logic [W-1:0] dly_data
);

    logic [DEPTH-1:0] v_q;
    logic [W-1:0]     d_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            v_q[0] <= valid;
            d_q[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign dly_valid = v_q[DEPTH-1];
    assign dly_data  = d_q[DEPTH-1];

endmodule

// File: rtl/fft_agu_stream.sv
// Runtime-sized radix-2 FFT address generator for ping-pong banked, in-place butterflies.
// Latency: first read 1 cycle after start; each write WR_LATENCY cycles after its read handshake.
// Backpressure: read side stalls on rd_ready=0 (outputs held); write side has none.
// Ports: start/log2n select a run; busy/done/result_bank report it; rd_* present butterfly
// pairs and twiddle index with valid/ready; wr_* strobe the matching write-back pairs.
module fft_agu_stream
    import fft_pkg::*;
#(
    parameter int MAX_LOG2N  = MAX_LOG2N_DEF,
    parameter int WR_LATENCY = 5,
    parameter int TW_WIDTH   = MAX_LOG2N - 1
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           start,
    input  logic [$clog2(MAX_LOG2N+1)-1:0] log2n,
    output logic                           busy,
    output logic                           done,
    output logic                           result_bank,
    output logic [$clog2(MAX_LOG2N)-1:0]   stage,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [MAX_LOG2N-1:0]           rd_addr_a,
    output logic [MAX_LOG2N-1:0]           rd_addr_b,
    output logic [TW_WIDTH-1:0]            tw_addr,
    output logic                           rd_bank,
    output logic                           wr_valid,
    output logic [MAX_LOG2N-1:0]           wr_addr_a,
    output logic [MAX_LOG2N-1:0]           wr_addr_b,
    output logic                           wr_bank
);

    localparam int LW = $clog2(MAX_LOG2N + 1);
    localparam int SW = $clog2(MAX_LOG2N);
    localparam int JW = (MAX_LOG2N > 1) ? MAX_LOG2N - 1 : 1;
    localparam int CW = $clog2(WR_LATENCY + 2);
    localparam int DW = 2 * MAX_LOG2N + 1;

    agu_state_t    state;
    logic [LW-1:0] l_q;
    logic [SW-1:0] s_q;
    logic [JW-1:0] j_q;
    logic [CW-1:0] inflight;

    logic [31:0]   a_full;
    logic [31:0]   b_full;
    logic [31:0]   tw_full;
    logic          hs;
    logic          last_pair;
    logic          last_stage;
    logic          log2n_ok;
    logic [DW-1:0] push_dat;
    logic [DW-1:0] wr_dat;

    always_comb begin
        int li;
        int si;
        li         = int'(l_q);
        si         = int'(s_q);
        a_full     = rotl_l(32'({j_q, 1'b0}), si, li);
        b_full     = rotl_l(32'({j_q, 1'b1}), si, li);
        tw_full    = tw_mask(32'(j_q), si, li);
        last_pair  = (li >= 1) && (32'(j_q) == ((32'd1 << (li - 1)) - 32'd1));
        last_stage = (si == li - 1);
    end

    assign log2n_ok = (log2n != '0) && (int'(log2n) <= MAX_LOG2N);
    assign hs       = rd_valid & rd_ready;

    // Addresses are forced to 0 outside ISSUE so idle/reset outputs read as 0.
    assign rd_addr_a = rd_valid ? a_full[MAX_LOG2N-1:0] : '0;
    assign rd_addr_b = rd_valid ? b_full[MAX_LOG2N-1:0] : '0;
    assign tw_addr   = rd_valid ? tw_full[TW_WIDTH-1:0] : '0;
    assign stage     = s_q;

    // Payload gated by the handshake so empty delay slots carry zeros.
    assign push_dat = hs ? {rd_addr_a, rd_addr_b, ~rd_bank} : '0;

    fft_agu_delay #(
        .W     (DW),
        .DEPTH (WR_LATENCY)
    ) u_delay (
        .clk       (clk),
        .clr       (clr),
        .valid     (hs),
        .data      (push_dat),
        .dly_valid (wr_valid),
        .dly_data  (wr_dat)
    );

    assign {wr_addr_a, wr_addr_b, wr_bank} = wr_dat;

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            l_q         <= '0;
            s_q         <= '0;
            j_q         <= '0;
            inflight    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_bank <= 1'b0;
            rd_valid    <= 1'b0;
            rd_bank     <= 1'b0;
        end else begin
            done     <= 1'b0;
            // Simultaneous issue and retire cancel out.
            inflight <= inflight + CW'(hs) - CW'(wr_valid);
            case (state)
                ST_IDLE: begin
                    if (start && log2n_ok) begin
                        l_q      <= log2n;
                        s_q      <= '0;
                        j_q      <= '0;
                        rd_bank  <= 1'b0;
                        busy     <= 1'b1;
                        rd_valid <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (hs) begin
                        if (last_pair) begin
                            rd_valid <= 1'b0;
                            state    <= ST_DRAIN;
                        end else begin
                            j_q <= j_q + JW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // The next stage reads what this stage wrote, so wait for every write.
                    if (inflight == '0) begin
                        if (last_stage) begin
                            done        <= 1'b1;
                            result_bank <= l_q[0];
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            s_q      <= s_q + SW'(1);
                            j_q      <= '0;
                            rd_bank  <= ~rd_bank;
                            rd_valid <= 1'b1;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
